// File: rtl/digit_line_renderer_if.sv
// Character-ROM access bus: address and read strobe out, combinational row byte back.
interface digit_line_renderer_if;
    logic [5:0] romAddr;
    logic       romRd;
    logic [7:0] romData;

    modport master (output romAddr, output romRd, input romData);
    modport slave  (input romAddr, input romRd, output romData);
endinterface

// File: rtl/digit_line_renderer.sv
// Renders one scan-line slice of a row of digit glyphs as a serial pixel stream,
// keeping one row byte prefetched from the shared character ROM.
module digit_line_renderer #(
    parameter int NUM_CHARS = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     startLine,
    input  logic [3:0]               rowSel,
    input  logic [3*NUM_CHARS-1:0]   digits,
    input  logic                     pixEn,
    digit_line_renderer_if.master    rom,
    output logic                     pixOut,
    output logic                     pixValid,
    output logic                     busy,
    output logic                     lineDone
);
    localparam int CW = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam int IW = CW + 2;
    localparam logic [CW-1:0] LAST_IDX  = CW'(NUM_CHARS - 1);
    localparam logic [IW-1:0] NUM_CELLS = IW'(NUM_CHARS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME0 = 2'd1,
        ST_PRIME1 = 2'd2,
        ST_SHIFT  = 2'd3
    } state_t;

    function automatic logic [2:0] cell_code(input logic [3*NUM_CHARS-1:0] d,
                                             input logic [IW-1:0] idx);
        logic [31:0]            pos;
        logic [3*NUM_CHARS-1:0] sh;
        pos = 32'(idx) * 32'd3;
        sh  = d >> pos;
        return sh[2:0];
    endfunction

    state_t                 state_r;
    logic [3:0]             row_r;
    logic [3*NUM_CHARS-1:0] digits_r;
    logic [CW-1:0]          char_idx_r;
    logic [2:0]             bit_cnt_r;
    logic [7:0]             shift_r;
    logic [7:0]             next_byte_r;
    logic                   next_valid_r;
    logic                   rom_blank_r;
    logic [5:0]             rom_addr_r;
    logic                   rom_rd_r;
    logic                   pix_out_r;
    logic                   pix_valid_r;
    logic                   busy_r;
    logic                   line_done_r;

    logic [2:0]             first_cell_s;
    logic [2:0]             second_cell_s;
    logic [IW-1:0]          refill_idx_s;
    logic [2:0]             refill_cell_s;
    logic [7:0]             fetched_s;

    // Cell codes for the prime fetches and the refill that follows each byte load.
    always_comb begin
        first_cell_s  = cell_code(digits, {IW{1'b0}});
        second_cell_s = cell_code(digits_r, IW'(1));
        refill_idx_s  = IW'(char_idx_r) + IW'(2);
        refill_cell_s = cell_code(digits_r, refill_idx_s);
        if (rom_blank_r) begin
            fetched_s = 8'h00;
        end else begin
            fetched_s = rom.romData;
        end
    end

    // Line sequencer: the ROM address/strobe are registered one cycle ahead so the
    // byte is sampled in the very cycle romRd is high.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            row_r        <= 4'd0;
            digits_r     <= {(3*NUM_CHARS){1'b0}};
            char_idx_r   <= {CW{1'b0}};
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            next_byte_r  <= 8'h00;
            next_valid_r <= 1'b0;
            rom_blank_r  <= 1'b0;
            rom_addr_r   <= 6'd0;
            rom_rd_r     <= 1'b0;
            pix_out_r    <= 1'b0;
            pix_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            line_done_r  <= 1'b0;
        end else begin
            pix_valid_r <= 1'b0;
            line_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (startLine) begin
                        row_r       <= rowSel;
                        digits_r    <= digits;
                        char_idx_r  <= {CW{1'b0}};
                        bit_cnt_r   <= 3'd0;
                        rom_addr_r  <= {first_cell_s[1:0], rowSel};
                        rom_blank_r <= first_cell_s[2];
                        rom_rd_r    <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ST_PRIME0;
                    end
                end
                ST_PRIME0: begin
                    shift_r     <= fetched_s;
                    bit_cnt_r   <= 3'd0;
                    rom_addr_r  <= {second_cell_s[1:0], row_r};
                    rom_blank_r <= second_cell_s[2];
                    rom_rd_r    <= 1'b1;
                    state_r     <= ST_PRIME1;
                end
                ST_PRIME1: begin
                    next_byte_r  <= fetched_s;
                    next_valid_r <= 1'b1;
                    rom_rd_r     <= 1'b0;
                    state_r      <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (rom_rd_r && !next_valid_r) begin
                        next_byte_r  <= fetched_s;
                        next_valid_r <= 1'b1;
                        rom_rd_r     <= 1'b0;
                    end
                    if (pixEn) begin
                        pix_out_r   <= shift_r[7];
                        pix_valid_r <= 1'b1;
                        bit_cnt_r   <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            if (char_idx_r == LAST_IDX) begin
                                line_done_r <= 1'b1;
                                busy_r      <= 1'b0;
                                rom_addr_r  <= 6'd0;
                                rom_rd_r    <= 1'b0;
                                state_r     <= ST_IDLE;
                            end else begin
                                shift_r      <= next_byte_r;
                                next_valid_r <= 1'b0;
                                char_idx_r   <= char_idx_r + CW'(1);
                                // Queue the fetch for the cell after the one just loaded.
                                if (refill_idx_s < NUM_CELLS) begin
                                    rom_addr_r  <= {refill_cell_s[1:0], row_r};
                                    rom_blank_r <= refill_cell_s[2];
                                    rom_rd_r    <= 1'b1;
                                end
                            end
                        end else begin
                            shift_r <= {shift_r[6:0], 1'b0};
                        end
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    busy_r   <= 1'b0;
                    rom_rd_r <= 1'b0;
                end
            endcase
        end
    end

    assign rom.romAddr = rom_addr_r;
    assign rom.romRd   = rom_rd_r;
    assign pixOut      = pix_out_r;
    assign pixValid    = pix_valid_r;
    assign busy        = busy_r;
    assign lineDone    = line_done_r;
endmodule

// File: doc/digit_line_renderer.md
# digit_line_renderer

Sequencer that drives the shared character ROM (6-bit address = {glyph[1:0], row[3:0]}, 8-bit row byte, combinational read) to render one scan-line slice of a row of NUM_CHARS digits. It is started once per active video line by the VGA timing logic and serialises glyph rows MSB-first into a 1-bit pixel stream, paced by a pixel enable. Row bytes are prefetched into a one-deep buffer so the stream never stalls.

## Interface
- NUM_CHARS, 4, number of character cells per line (2..16)
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low
- startLine  in  1  one-clock start pulse, honoured only in IDLE
- rowSel  in  4  glyph row (0..15) for this line, captured at start
- digits  in  3*NUM_CHARS  cell k code in bits [3k+2:3k]; bit 2 = blank, bits 1:0 = glyph; captured at start
- pixEn  in  1  pixel strobe; at most one pixel consumed per assertion
- romAddr  out  6  ROM address, {glyph, row}
- romRd  out  1  high in the cycle the ROM output is sampled
- romData  in  8  ROM row byte, valid same cycle as romAddr
- pixOut  out  1  registered pixel value
- pixValid  out  1  one-clock qualifier for pixOut
- busy  out  1  high outside IDLE
- lineDone  out  1  one-clock pulse with the final pixel

## Operation
- States: IDLE, PRIME0, PRIME1, SHIFT.
- IDLE: busy=0, romAddr=0, romRd=0. startLine=1 → latch rowSel, digits; charIdx=0; → PRIME0. startLine outside IDLE ignored.
- PRIME0: romAddr={digit[0][1:0], row}, romRd=1; shiftReg ← romData (0x00 if digit[0][2]=1); bitCnt=0; → PRIME1.
- PRIME1: same for cell 1 into nextByte; nextValid=1; → SHIFT.
- SHIFT, on pixEn: pixOut ← shiftReg[7], pixValid ← 1, shiftReg ← shiftReg<<1, bitCnt++.
  - bitCnt==7 and charIdx<NUM_CHARS-1: shiftReg ← nextByte, nextValid=0, charIdx++, bitCnt=0.
  - bitCnt==7 and charIdx==NUM_CHARS-1: lineDone ← 1, → IDLE.
- Refill: in any SHIFT cycle with nextValid=0 and charIdx+1<NUM_CHARS, romAddr={digit[charIdx+1][1:0], row}, romRd=1, nextByte ← romData (or 0x00 if blank), nextValid=1. The refill and a pixEn in the same cycle are independent; refill always completes ≥7 pixels before it is needed.
- In SHIFT with no refill pending, romAddr holds its last value and romRd=0.
- Blank cells emit eight 0 pixels; the ROM is still addressed (romRd=1) for uniform timing.
- pixEn in IDLE, PRIME0 or PRIME1 is ignored (no pixel consumed, pixValid=0).
- charIdx width = clog2(NUM_CHARS); bitCnt 3 bits, wraps 7→0.

## Timing
- Reset (reset=0 at clock edge): state=IDLE, pixOut=0, pixValid=0, lineDone=0, busy=0, romAddr=0, romRd=0, all internal registers 0. Reset mid-line aborts immediately; no lineDone.
- startLine at edge T → busy=1 from T+1; PRIME0 in cycle T+1, PRIME1 in T+2; first pixEn honoured at T+3.
- pixOut/pixValid are registered: pixel for pixEn at edge N appears after edge N; pixValid=0 in every cycle not following an honoured pixEn.
- Line = exactly 8*NUM_CHARS honoured pixEn; lineDone and busy deassertion coincide with last pixValid.
- startLine in the same cycle as the final pixEn is ignored (state not yet IDLE); earliest restart is the following cycle.
- Back-to-back pixEn (every clock) is supported with no gaps.

## Test plan
- Reset: hold reset=0 3 clocks while startLine=1 and pixEn=1 → all outputs 0, busy=0; release → still IDLE.
- Basic line, NUM_CHARS=4, bench ROM returns romData={2'b10,romAddr}; digits={3'd3,3'd2,3'd1,3'd0}, rowSel=5, pixEn every clock → romAddr 0x05,0x15 in PRIME, then 0x25,0x35 as refills; 32 pixels equal to bytes 0x85,0x95,0xA5,0xB5 MSB-first; lineDone with 32nd pixValid.
- Blank cell: digits cell1=3'b100 → pixels 8..15 all 0, other cells unchanged, romRd still pulses for cell 1.
- Sparse pacing: pixEn every 2nd clock, also a run of 1-in-5 → same 32-bit pattern, one pixValid per pixEn, never a stall or duplicate.
- Ignored starts: startLine pulses at T+1, in SHIFT, and with the final pixEn → no restart, latched digits/row unchanged; startLine one clock after lineDone → new line starts.
- Reset mid-line after 13 pixels → IDLE next cycle, pixValid=0, no lineDone; new startLine renders a full fresh line.
